fft_window_loader: RTL

- Upstream stage of the 2048-point FFT. Accepts a stream of real ADC samples and multiplies each by its Hann coefficient from the external registered Hann LUT.
- Writes each windowed complex word ({re, im=0}) into the FFT working RAM at the bit-reversed address, so the FFT can run in-place decimation-in-time.
- After the 2048th write it pulses fft_start, then holds off input until the FFT reports done.

---
 rtl/fft_window_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fft_window_loader.sv
// fft_window_loader: front end of the 2048-point in-place DIT FFT.
// Takes real ADC samples, optionally applies a Hann window read from an
// external registered LUT, and writes {re, im=0} words into the FFT working
// RAM at bit-reversed addresses. Pulses fft_start when a frame is loaded, then
// refuses input until fft_done.
// Build option: define FFT_LOADER_HANN_EN to enable the windowed multiply;
// without it the window is rectangular and no multiplier is built.
module fft_window_loader #(
  parameter int width  = 16,
  parameter int N_LOG2 = 11
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic signed [width-6:0] sample,
  output logic                    sample_ready,
  output logic [N_LOG2-1:0]       win_idx,
  input  logic [width-1:0]        win_coef,
  output logic                    wr_en,
  output logic [N_LOG2-1:0]       wr_adr,
  output logic [2*width-1:0]      wr_data,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int SW = width - 5;  // sample width

  typedef enum logic [1:0] {
    FILL,
    FLUSH,
    START,
    WAIT
  } state_t;

  state_t                  state, state_nxt;
  logic [N_LOG2-1:0]       count;
  logic [N_LOG2-1:0]       count_rev;
  logic                    accept;
  logic signed [SW-1:0]    s1_sample;
  logic [N_LOG2-1:0]       s1_adr;
  logic                    v1;
  logic signed [SW-1:0]    re_w;
  logic [width-1:0]        re_ext;

  assign accept = sample_valid && (state == FILL);

  // Bit-reverse the sample index to get the DIT input ordering.
  always_comb begin
    for (int i = 0; i < N_LOG2; i++) begin
      count_rev[i] = count[N_LOG2-1-i];
    end
  end

`ifdef FFT_LOADER_HANN_EN
  logic signed [width:0]    coef_ext;
  logic signed [SW+width:0] product;
  logic                     unused_prod_bits;

  // LUT is addressed with the index being accepted so its registered output
  // lines up with stage 1 on the following cycle.
  assign win_idx  = (state == FILL) ? count : '0;
  assign coef_ext = {1'b0, win_coef};
  assign product  = s1_sample * coef_ext;
  // Arithmetic shift right by width: the slice floors toward -inf and the
  // result is guaranteed to fit in the sample width.
  assign re_w     = product[SW+width-1:width];
  assign unused_prod_bits = ^{product[SW+width], product[width-1:0]};
`else
  logic unused_coef;

  assign win_idx     = '0;
  assign re_w        = s1_sample;
  assign unused_coef = ^win_coef;
`endif

  assign re_ext = {{(width-SW){re_w[SW-1]}}, re_w};

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    fft_start    = 1'b0;
    busy         = 1'b0;
    case (state)
      FILL: begin
        sample_ready = 1'b1;
        if (sample_valid && (count == '1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Final write is on the bus once stage 1 has emptied.
        if (wr_en && !v1) state_nxt = START;
      end
      START: begin
        fft_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (fft_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Sample index counter; wraps to 0 after the last index of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
    end else if (state == WAIT && fft_done) begin
      count <= '0;
    end
  end

  // Stage 1: capture sample and its bit-reversed destination.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_sample <= '0;
      s1_adr    <= '0;
      v1        <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        s1_sample <= sample;
        s1_adr    <= count_rev;
      end
    end
  end

  // Stage 2: windowed word onto the RAM write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_adr  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= v1;
      if (v1) begin
        wr_adr  <= s1_adr;
        wr_data <= {re_ext, {width{1'b0}}};
      end
    end
  end

  // Sticky overrun: any sample offered while not ready is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         overrun <= 1'b0;
    else if (sample_valid && !sample_ready) overrun <= 1'b1;
  end

endmodule
